// File: rtl/oc8051_iram_arb_if.sv
// rtl/oc8051_iram_arb_if.sv - bus bundle between the two IRAM masters, the arbiter and the RAM
interface oc8051_iram_arb_if;
  logic       cpu_rd_req;
  logic [7:0] cpu_rd_addr;
  logic       cpu_rd_gnt;
  logic       cpu_rvalid;
  logic       cpu_wr_req;
  logic [7:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic       cpu_wr_gnt;
  logic       cpu_wr_err;

  logic       ldr_rd_req;
  logic [7:0] ldr_rd_addr;
  logic       ldr_rd_gnt;
  logic       ldr_rvalid;
  logic       ldr_wr_req;
  logic [7:0] ldr_wr_addr;
  logic [7:0] ldr_wr_data;
  logic       ldr_wr_gnt;

  logic       prot_on;
  logic [7:0] rd_data;

  logic [7:0] ram_rd_addr;
  logic       ram_rd_en;
  logic [7:0] ram_rd_data;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_wr;
  logic       ram_wr_en;

  // arbiter side
  modport slave (
    input  cpu_rd_req, cpu_rd_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    input  ldr_rd_req, ldr_rd_addr, ldr_wr_req, ldr_wr_addr, ldr_wr_data,
    input  prot_on, ram_rd_data,
    output cpu_rd_gnt, cpu_rvalid, cpu_wr_gnt, cpu_wr_err,
    output ldr_rd_gnt, ldr_rvalid, ldr_wr_gnt,
    output rd_data, ram_rd_addr, ram_rd_en, ram_wr_addr, ram_wr_data, ram_wr, ram_wr_en
  );

  // requester / RAM side
  modport master (
    output cpu_rd_req, cpu_rd_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    output ldr_rd_req, ldr_rd_addr, ldr_wr_req, ldr_wr_addr, ldr_wr_data,
    output prot_on, ram_rd_data,
    input  cpu_rd_gnt, cpu_rvalid, cpu_wr_gnt, cpu_wr_err,
    input  ldr_rd_gnt, ldr_rvalid, ldr_wr_gnt,
    input  rd_data, ram_rd_addr, ram_rd_en, ram_wr_addr, ram_wr_data, ram_wr, ram_wr_en
  );
endinterface

// File: rtl/oc8051_iram_arb.sv
// rtl/oc8051_iram_arb.sv - CPU/loader IRAM arbiter with starvation bound; OC8051_IRAM_ARB_PROT_EN adds a CPU write-protect window
module oc8051_iram_arb #(
  parameter int         MAX_WAIT = 4,
  parameter int         WAIT_W   = 3,
  parameter logic [7:0] PROT_LO  = 8'h00,
  parameter logic [7:0] PROT_HI  = 8'h0F
) (
  input  logic                clk,
  input  logic                rst,
  oc8051_iram_arb_if.slave    bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] rd_wait;
  logic [WAIT_W-1:0] wr_wait;
  logic              cpu_rd_gnt;
  logic              ldr_rd_gnt;
  logic              cpu_wr_gnt;
  logic              ldr_wr_gnt;
  logic              cpu_rvalid_q;
  logic              ldr_rvalid_q;
  logic              wr_blocked;

  // Loader counter: count denied cycles up to the limit, drop to zero on grant or idle.
  function automatic logic [WAIT_W-1:0] wait_next(input logic req, input logic gnt,
                                                  input logic [WAIT_W-1:0] cur);
    if (req && !gnt) begin
      return (cur == WAIT_LIM) ? cur : cur + WAIT_W'(1);
    end
    return '0;
  endfunction

  // Per-port arbitration: CPU wins unless the loader has waited MAX_WAIT contested cycles.
  always_comb begin
    cpu_rd_gnt = rst & bus.cpu_rd_req & ~(bus.ldr_rd_req & (rd_wait == WAIT_LIM));
    ldr_rd_gnt = rst & bus.ldr_rd_req & (~bus.cpu_rd_req | (rd_wait == WAIT_LIM));
    cpu_wr_gnt = rst & bus.cpu_wr_req & ~(bus.ldr_wr_req & (wr_wait == WAIT_LIM));
    ldr_wr_gnt = rst & bus.ldr_wr_req & (~bus.cpu_wr_req | (wr_wait == WAIT_LIM));
  end

  // Starvation counters and read-valid flags; a grant in a reset cycle yields no rvalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_wait      <= '0;
      wr_wait      <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      rd_wait      <= wait_next(bus.ldr_rd_req, ldr_rd_gnt, rd_wait);
      wr_wait      <= wait_next(bus.ldr_wr_req, ldr_wr_gnt, wr_wait);
      cpu_rvalid_q <= cpu_rd_gnt;
      ldr_rvalid_q <= ldr_rd_gnt;
    end
  end

`ifdef OC8051_IRAM_ARB_PROT_EN
  logic wr_err_q;

  assign wr_blocked = bus.prot_on & cpu_wr_gnt &
                      (bus.cpu_wr_addr >= PROT_LO) & (bus.cpu_wr_addr <= PROT_HI);

  // One-cycle error pulse following a CPU write swallowed by the protection window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_blocked;
    end
  end

  assign bus.cpu_wr_err = wr_err_q;
`else
  assign wr_blocked     = 1'b0;
  assign bus.cpu_wr_err = 1'b0;
`endif

  assign bus.cpu_rd_gnt = cpu_rd_gnt;
  assign bus.ldr_rd_gnt = ldr_rd_gnt;
  assign bus.cpu_wr_gnt = cpu_wr_gnt;
  assign bus.ldr_wr_gnt = ldr_wr_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.rd_data    = bus.ram_rd_data;

  // RAM-side muxing from whichever master holds each port; idle ports present zero.
  always_comb begin
    bus.ram_rd_en   = cpu_rd_gnt | ldr_rd_gnt;
    bus.ram_rd_addr = ldr_rd_gnt ? bus.ldr_rd_addr :
                      cpu_rd_gnt ? bus.cpu_rd_addr : 8'h00;
    bus.ram_wr      = ldr_wr_gnt | (cpu_wr_gnt & ~wr_blocked);
    bus.ram_wr_en   = ldr_wr_gnt | (cpu_wr_gnt & ~wr_blocked);
    bus.ram_wr_addr = ldr_wr_gnt ? bus.ldr_wr_addr :
                      cpu_wr_gnt ? bus.cpu_wr_addr : 8'h00;
    bus.ram_wr_data = ldr_wr_gnt ? bus.ldr_wr_data :
                      cpu_wr_gnt ? bus.cpu_wr_data : 8'h00;
  end

endmodule
